// File: rtl/char_flush_fsm.sv
// Character cell scanner: walks a CHAR_W x CHAR_H cell row-major, presents
// each pixel coordinate to the glyph LUT and turns the LUT answer into a
// registered plot write one cycle later.
module char_flush_fsm #(
  parameter int unsigned CHAR_W      = 10,
  parameter int unsigned CHAR_H      = 10,
  parameter bit          TRANSPARENT = 1'b1,
  parameter logic [5:0]  BG_COLOUR   = 6'b000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] char_x,
  input  logic [7:0] char_y,
  input  logic       glyph_enable,
  input  logic [5:0] glyph_colour,
  output logic [7:0] flush_x,
  output logic [7:0] flush_y,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [5:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] ColLast = 4'(CHAR_W - 1);
  localparam logic [3:0] RowLast = 4'(CHAR_H - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] origin_x_q, origin_x_d;
  logic [7:0] origin_y_q, origin_y_d;
  logic [3:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [5:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;

  // Coordinates wrap mod 256; the LUT subtracts mod 256 too, so offsets survive.
  assign flush_x = origin_x_q + {4'b0000, col_q};
  assign flush_y = origin_y_q + {4'b0000, row_q};

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

  // State, origin, counters and plot registers; reset aborts any scan at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      origin_x_q   <= 8'd0;
      origin_y_q   <= 8'd0;
      col_q        <= 4'd0;
      row_q        <= 4'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 8'd0;
      vga_colour_q <= 6'd0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      origin_x_q   <= origin_x_d;
      origin_y_q   <= origin_y_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  // Next-state: accept start in idle, scan row-major, hold last pixel in done.
  always_comb begin
    state_d      = state_q;
    origin_x_d   = origin_x_q;
    origin_y_d   = origin_y_q;
    col_d        = col_q;
    row_d        = row_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = vga_plot_q;

    case (state_q)
      StIdle: begin
        col_d      = 4'd0;
        row_d      = 4'd0;
        vga_plot_d = 1'b0;
        if (start) begin
          origin_x_d = char_x;
          origin_y_d = char_y;
          state_d    = StScan;
        end
      end
      StScan: begin
        vga_x_d      = flush_x;
        vga_y_d      = flush_y;
        vga_colour_d = glyph_enable ? glyph_colour : BG_COLOUR;
        vga_plot_d   = glyph_enable | !TRANSPARENT;
        if (col_q == ColLast) begin
          col_d = 4'd0;
          if (row_q == RowLast) begin
            row_d   = 4'd0;
            state_d = StDone;
          end else begin
            row_d = row_q + 4'd1;
          end
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      StDone: begin
        // Last pixel stays visible for this cycle so done lines up with it.
        vga_plot_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_char_flush_fsm.sv
// Bench for char_flush_fsm: a transparent and an opaque instance, each fed by
// a 'y' glyph LUT model, with plot writes checked against a queue of expected
// pixels built from the origin and glyph.
module tb_char_flush_fsm;

  localparam int W    = 10;
  localparam int H    = 10;
  localparam int CELL = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start2;
  logic [7:0] char_x, char_y;
  logic       ge1, ge2;
  logic [5:0] gc1, gc2;
  logic [7:0] fx1, fy1, vx1, vy1, fx2, fy2, vx2, vy2;
  logic [5:0] vc1, vc2;
  logic       vp1, vp2, busy1, busy2, done1, done2;

  logic [7:0] org1_x, org1_y, org2_x, org2_y;
  logic [21:0] exp1[$];
  logic [21:0] exp2[$];

  int tests = 0;
  int fails = 0;
  int plots1 = 0;
  int dones1 = 0;
  int dones2 = 0;

  always #5 clk = ~clk;

  char_flush_fsm u_dut (
    .clk(clk), .reset(reset), .start(start), .char_x(char_x), .char_y(char_y),
    .glyph_enable(ge1), .glyph_colour(gc1), .flush_x(fx1), .flush_y(fy1),
    .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .vga_plot(vp1),
    .busy(busy1), .done(done1)
  );

  char_flush_fsm #(.CHAR_W(10), .CHAR_H(10), .TRANSPARENT(1'b0), .BG_COLOUR(6'h05)) u_dut_bg (
    .clk(clk), .reset(reset), .start(start2), .char_x(char_x), .char_y(char_y),
    .glyph_enable(ge2), .glyph_colour(gc2), .flush_x(fx2), .flush_y(fy2),
    .vga_x(vx2), .vga_y(vy2), .vga_colour(vc2), .vga_plot(vp2),
    .busy(busy2), .done(done2)
  );

  // 'y' glyph: arms on rows 0-3, stem on columns 4-5 for rows 4-9 (20 pixels).
  function automatic logic glyph_on(input logic [7:0] dx, input logic [7:0] dy);
    logic [9:0] m;
    if (dx >= 8'd10 || dy >= 8'd10) return 1'b0;
    case (dy)
      8'd0, 8'd1: m = 10'b0010000100;
      8'd2, 8'd3: m = 10'b0001001000;
      default:    m = 10'b0000110000;
    endcase
    return m[dx[3:0]];
  endfunction

  // LUT models: combinational return for the presented flush coordinate.
  always_comb begin
    ge1 = glyph_on(fx1 - org1_x, fy1 - org1_y);
    gc1 = ge1 ? 6'h3F : 6'h2A;
    ge2 = glyph_on(fx2 - org2_x, fy2 - org2_y);
    gc2 = ge2 ? 6'h3F : 6'h2A;
  end

  task automatic push_cell1(input logic [7:0] ox, input logic [7:0] oy);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (glyph_on(8'(c), 8'(r))) exp1.push_back({8'(ox + 8'(c)), 8'(oy + 8'(r)), 6'h3F});
  endtask

  task automatic push_cell2(input logic [7:0] ox, input logic [7:0] oy);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp2.push_back({8'(ox + 8'(c)), 8'(oy + 8'(r)),
                        glyph_on(8'(c), 8'(r)) ? 6'h3F : 6'h05});
  endtask

  // One clock edge, then sample and drain the scoreboards.
  task automatic tick();
    logic [21:0] e;
    @(posedge clk);
    #1;
    if (vp1) begin
      plots1++;
      tests++;
      if (exp1.size() == 0) begin
        fails++;
        $display("FAIL plot1_unexpected: got (%0d,%0d,%h), required no plot", vx1, vy1, vc1);
      end else begin
        e = exp1.pop_front();
        if ({vx1, vy1, vc1} !== e) begin
          fails++;
          $display("FAIL plot1: got (%0d,%0d,%h), required (%0d,%0d,%h)",
                   vx1, vy1, vc1, e[21:14], e[13:6], e[5:0]);
        end
      end
    end
    if (vp2) begin
      tests++;
      if (exp2.size() == 0) begin
        fails++;
        $display("FAIL plot2_unexpected: got (%0d,%0d,%h), required no plot", vx2, vy2, vc2);
      end else begin
        e = exp2.pop_front();
        if ({vx2, vy2, vc2} !== e) begin
          fails++;
          $display("FAIL plot2: got (%0d,%0d,%h), required (%0d,%0d,%h)",
                   vx2, vy2, vc2, e[21:14], e[13:6], e[5:0]);
        end
      end
    end
    if (done1) dones1++;
    if (done2) dones2++;
  endtask

  // Render one cell on the transparent instance, checking flush order,
  // start-to-done latency, busy length and the return to idle.
  task automatic run_cell1(input logic [7:0] ox, input logic [7:0] oy, input string name);
    int n, nbusy, p0, d0;
    logic [7:0] efx, efy;
    org1_x = ox; org1_y = oy;
    push_cell1(ox, oy);
    p0 = plots1; d0 = dones1;
    char_x = ox; char_y = oy; start = 1'b1;
    n = 0; nbusy = 0;
    while (n < 300) begin
      tick();
      n++;
      if (n == 1) start = 1'b0;
      if (busy1) nbusy++;
      if (n <= CELL) begin
        efx = ox + 8'((n - 1) % W);
        efy = oy + 8'((n - 1) / W);
        tests++;
        if (fx1 !== efx || fy1 !== efy) begin
          fails++;
          $display("FAIL %s_flush[%0d]: got (%0d,%0d), required (%0d,%0d)",
                   name, n - 1, fx1, fy1, efx, efy);
        end
      end
      if (done1) break;
    end
    tests++;
    if (n !== CELL + 1) begin
      fails++;
      $display("FAIL %s_latency: got %0d edges, required %0d", name, n, CELL + 1);
    end
    tick();
    tests++;
    if (busy1 !== 1'b0 || vp1 !== 1'b0 || done1 !== 1'b0 || fx1 !== ox || fy1 !== oy) begin
      fails++;
      $display("FAIL %s_idle: got busy=%b plot=%b done=%b flush=(%0d,%0d), required 0 0 0 (%0d,%0d)",
               name, busy1, vp1, done1, fx1, fy1, ox, oy);
    end
    tests++;
    if (nbusy !== CELL + 1 || plots1 - p0 !== 20 || dones1 - d0 !== 1 || exp1.size() !== 0) begin
      fails++;
      $display("FAIL %s_totals: got busy=%0d plots=%0d dones=%0d left=%0d, required %0d 20 1 0",
               name, nbusy, plots1 - p0, dones1 - d0, exp1.size(), CELL + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0; char_x = 8'd0; char_y = 8'd0;
    org1_x = 8'd0; org1_y = 8'd0; org2_x = 8'd0; org2_y = 8'd0;
    #3;
    tests++;
    if ({fx1, fy1, vx1, vy1, vc1, vp1, busy1, done1} !== 48'd0) begin
      fails++;
      $display("FAIL reset_dut1: got %h, required 0", {fx1, fy1, vx1, vy1, vc1, vp1, busy1, done1});
    end
    tests++;
    if ({fx2, fy2, vx2, vy2, vc2, vp2, busy2, done2} !== 48'd0) begin
      fails++;
      $display("FAIL reset_dut2: got %h, required 0", {fx2, fy2, vx2, vy2, vc2, vp2, busy2, done2});
    end
    #9 reset = 1'b0;
    tick();
    tests++;
    if (busy1 !== 1'b0 || vp1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b plot=%b, required 0 0", busy1, vp1);
    end
  endtask

  task automatic test_transparent();
    run_cell1(8'd20, 8'd30, "transparent");
  endtask

  task automatic test_opaque();
    int n, nbusy, run, maxrun, c05, c3f, np;
    org2_x = 8'd20; org2_y = 8'd30;
    push_cell2(8'd20, 8'd30);
    char_x = 8'd20; char_y = 8'd30; start2 = 1'b1;
    n = 0; nbusy = 0; run = 0; maxrun = 0; c05 = 0; c3f = 0; np = 0;
    while (n < 300) begin
      tick();
      n++;
      if (n == 1) start2 = 1'b0;
      if (busy2) nbusy++;
      if (vp2) begin
        np++; run++;
        if (run > maxrun) maxrun = run;
        if (vc2 == 6'h05) c05++;
        if (vc2 == 6'h3F) c3f++;
      end else begin
        run = 0;
      end
      if (!busy2 && n > CELL + 1) break;
    end
    tests++;
    if (np !== CELL || maxrun !== CELL) begin
      fails++;
      $display("FAIL opaque_plots: got %0d plots run %0d, required %0d consecutive", np, maxrun, CELL);
    end
    tests++;
    if (c05 !== 80 || c3f !== 20) begin
      fails++;
      $display("FAIL opaque_colours: got bg=%0d fg=%0d, required 80 20", c05, c3f);
    end
    tests++;
    if (nbusy !== CELL + 1 || dones2 !== 1 || exp2.size() !== 0) begin
      fails++;
      $display("FAIL opaque_busy: got busy=%0d dones=%0d left=%0d, required %0d 1 0",
               nbusy, dones2, exp2.size(), CELL + 1);
    end
  endtask

  task automatic test_wrap();
    run_cell1(8'd250, 8'd250, "wrap");
  endtask

  task automatic test_start_ignored();
    int n, d0;
    org1_x = 8'd60; org1_y = 8'd70;
    push_cell1(8'd60, 8'd70);
    d0 = dones1;
    char_x = 8'd60; char_y = 8'd70; start = 1'b1;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (n == 1 || n == 51) start = 1'b0;
      if (n == 50) begin
        start = 1'b1; char_x = 8'd99; char_y = 8'd77;
      end
      if (done1) break;
    end
    tests++;
    if (n !== CELL + 1) begin
      fails++;
      $display("FAIL ignore_latency: got %0d edges, required %0d", n, CELL + 1);
    end
    // Pulse during done; it must not queue a scan.
    start = 1'b1; char_x = 8'd5; char_y = 8'd6;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (busy1 !== 1'b0 || dones1 - d0 !== 1 || exp1.size() !== 0) begin
      fails++;
      $display("FAIL ignore_done: got busy=%b dones=%0d left=%0d, required 0 1 0",
               busy1, dones1 - d0, exp1.size());
    end
    run_cell1(8'd5, 8'd6, "restart");
  endtask

  task automatic test_reset_abort();
    int n, d0;
    org1_x = 8'd100; org1_y = 8'd40;
    push_cell1(8'd100, 8'd40);
    d0 = dones1;
    char_x = 8'd100; char_y = 8'd40; start = 1'b1;
    for (n = 1; n <= 38; n++) begin
      tick();
      start = 1'b0;
    end
    tests++;
    if (vp1 !== 1'b1 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: got plot=%b busy=%b, required 1 1", vp1, busy1);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (vp1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: got plot=%b busy=%b done=%b, required 0 0 0", vp1, busy1, done1);
    end
    exp1.delete();
    tick();
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (dones1 !== d0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL abort_nodone: got dones=%0d busy=%b, required %0d 0", dones1 - d0, busy1, 0);
    end
    run_cell1(8'd0, 8'd0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n, nd, d0;
    int de[3];
    org1_x = 8'd40; org1_y = 8'd60;
    for (int k = 0; k < 3; k++) push_cell1(8'd40, 8'd60);
    d0 = dones1;
    char_x = 8'd40; char_y = 8'd60; start = 1'b1;
    n = 0; nd = 0;
    while (n < 400) begin
      tick();
      n++;
      if (done1) begin
        if (nd < 3) de[nd] = n;
        nd++;
        if (nd == 3) start = 1'b0;
      end
      if (nd >= 3 && !busy1) break;
    end
    tests++;
    if (nd !== 3 || dones1 - d0 !== 3) begin
      fails++;
      $display("FAIL b2b_dones: got %0d, required 3", nd);
    end else begin
      tests++;
      if (de[0] !== CELL + 1 || de[1] - de[0] !== CELL + 2 || de[2] - de[1] !== CELL + 2) begin
        fails++;
        $display("FAIL b2b_period: got %0d,%0d,%0d, required %0d then period %0d",
                 de[0], de[1] - de[0], de[2] - de[1], CELL + 1, CELL + 2);
      end
    end
    tests++;
    if (exp1.size() !== 0) begin
      fails++;
      $display("FAIL b2b_plots: got %0d left, required 0", exp1.size());
    end
  endtask

  initial begin
    test_reset();
    test_transparent();
    test_opaque();
    test_wrap();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
